// File: rtl/test_pkg.sv
// Shared types and constants for the self-test result collector and its UART.
package test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REPORT   = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_PASS    = 8'h50;
  localparam logic [7:0] CHAR_FAIL    = 8'h46;
  localparam logic [7:0] CHAR_TIMEOUT = 8'h54;
  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_LF      = 8'h0A;

  localparam int FRAME_BITS = 10;

  // A timeout outranks a failure in the per-unit report character.
  function automatic logic [7:0] verdict_char(input logic timed_out, input logic failed);
    logic [7:0] c;
    if (timed_out) begin
      c = CHAR_TIMEOUT;
    end else if (failed) begin
      c = CHAR_FAIL;
    end else begin
      c = CHAR_PASS;
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter, one byte per valid/ready handshake, back-to-back capable.
module uart_tx_byte
  import test_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic [FRAME_BITS-1:0] shift_r;
  logic [DIV_W-1:0]      div_cnt_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic                  active_r;
  logic                  last_tick_s;
  logic                  frame_end_s;

  assign last_tick_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign frame_end_s = last_tick_s && (bit_cnt_r == BIT_W'(FRAME_BITS - 1));
  // Accepting during the final stop-bit cycle lets the next start bit follow with no gap.
  assign ready       = !active_r || frame_end_s;
  assign tx          = shift_r[0];

  // Frame shifter and bit timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= {FRAME_BITS{1'b1}};
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      active_r  <= 1'b0;
    end else if (valid && ready) begin
      shift_r   <= {1'b1, data, 1'b0};
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      active_r  <= 1'b1;
    end else if (active_r) begin
      if (frame_end_s) begin
        active_r <= 1'b0;
      end else if (last_tick_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        shift_r   <= {1'b1, shift_r[FRAME_BITS-1:1]};
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/test_result_collector.sv
// Collects per-unit self-test verdicts with a timeout, drives pass/fail and
// serialises a one-character-per-unit report (then CR LF) over UART.
module test_result_collector
  import test_pkg::*;
#(
  parameter int N_UNITS        = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CLK_DIV        = 104
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_UNITS-1:0] unit_result,
  input  logic [N_UNITS-1:0] unit_done,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic               complete,
  output logic               uart_tx
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = $clog2(N_UNITS + 3);
  // Byte index value meaning every report byte has been handed to the UART.
  localparam logic [IDX_W-1:0] ALL_SENT = IDX_W'(N_UNITS + 2);

  state_t             state_r, state_nxt_s;
  logic [N_UNITS-1:0] done_l_r, fail_l_r, to_l_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   byte_idx_r;
  logic               busy_r, pass_r, fail_r, complete_r;
  logic               arm_s, all_done_s, timeout_s, verdict_fail_s;
  logic               tx_valid_s, tx_ready_s;
  logic [7:0]         tx_data_s, unit_char_s;

  assign all_done_s     = &(done_l_r | unit_done);
  assign timeout_s      = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign verdict_fail_s = |(fail_l_r | to_l_r);

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    arm_s       = 1'b0;
    tx_valid_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_COMPLETE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          arm_s       = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (all_done_s || timeout_s) begin
          state_nxt_s = ST_REPORT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_REPORT: begin
        if (byte_idx_r == ALL_SENT) begin
          state_nxt_s = tx_ready_s ? ST_COMPLETE : ST_REPORT;
        end else begin
          tx_valid_s  = 1'b1;
          state_nxt_s = ST_REPORT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Report character for the current byte index.
  always_comb begin
    unit_char_s = 8'h00;
    for (int i = 0; i < N_UNITS; i++) begin
      unit_char_s = unit_char_s |
                    ((byte_idx_r == IDX_W'(i)) ? verdict_char(to_l_r[i], fail_l_r[i]) : 8'h00);
    end
    if (byte_idx_r < IDX_W'(N_UNITS)) begin
      tx_data_s = unit_char_s;
    end else if (byte_idx_r == IDX_W'(N_UNITS)) begin
      tx_data_s = CHAR_CR;
    end else begin
      tx_data_s = CHAR_LF;
    end
  end

  // State register and status outputs, all taken from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
      complete_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_REPORT);
      complete_r <= (state_nxt_s == ST_COMPLETE);
      pass_r     <= (state_nxt_s == ST_COMPLETE) && !verdict_fail_s;
      fail_r     <= (state_nxt_s == ST_COMPLETE) && verdict_fail_s;
    end
  end

  // Verdict latches, timeout counter and report byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_l_r   <= {N_UNITS{1'b0}};
      fail_l_r   <= {N_UNITS{1'b0}};
      to_l_r     <= {N_UNITS{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      byte_idx_r <= {IDX_W{1'b0}};
    end else if (arm_s) begin
      done_l_r   <= {N_UNITS{1'b0}};
      fail_l_r   <= {N_UNITS{1'b0}};
      to_l_r     <= {N_UNITS{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      byte_idx_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      done_l_r <= done_l_r | unit_done;
      // A failure flag seen at or before done is sticky; after done the unit is ignored.
      fail_l_r <= fail_l_r | (unit_result & ~done_l_r);
      if (cnt_r != CNT_W'(TIMEOUT_CYCLES)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (timeout_s && !all_done_s) begin
        to_l_r <= ~(done_l_r | unit_done);
      end
    end else if (state_r == ST_REPORT) begin
      if (tx_valid_s && tx_ready_s) begin
        byte_idx_r <= byte_idx_r + IDX_W'(1);
      end
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data_s),
    .valid(tx_valid_s),
    .ready(tx_ready_s),
    .tx   (uart_tx)
  );

  assign busy     = busy_r;
  assign pass     = pass_r;
  assign fail     = fail_r;
  assign complete = complete_r;

endmodule

// File: tb/tb_test_result_collector.sv
// Randomised bench for test_result_collector against a schedule-level reference model.
module tb_test_result_collector;

  localparam int N          = 3;
  localparam int DIV        = 4;
  localparam int TMO        = 64;
  localparam int FRAME_CYC  = 10 * DIV;
  localparam int REPORT_CYC = (N + 2) * FRAME_CYC;
  localparam int NEVER      = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] unit_result = '0;
  logic [N-1:0] unit_done = '0;
  logic         busy, pass, fail, complete, uart_tx;

  int checks = 0;
  int errors = 0;

  // Per-unit schedule: done cycle, lone result pulse cycle (0 = none), result at done.
  int dc[N];
  int fc[N];
  bit rd[N];

  always #5 clk = ~clk;

  test_result_collector #(
    .N_UNITS(N),
    .TIMEOUT_CYCLES(TMO),
    .CLK_DIV(DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .unit_result(unit_result),
    .unit_done  (unit_done),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .complete   (complete),
    .uart_tx    (uart_tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    unit_done   = N'($urandom);
    unit_result = N'($urandom);
  endtask

  // Unit inputs for RUN cycle k (k = 1 is the cycle after the arm pulse).
  task automatic drive_run(input int k);
    for (int i = 0; i < N; i++) begin
      if (k < dc[i]) begin
        unit_done[i]   = 1'b0;
        unit_result[i] = (k == fc[i]);
      end else if (k == dc[i]) begin
        unit_done[i]   = 1'b1;
        unit_result[i] = rd[i] || (k == fc[i]);
      end else begin
        unit_done[i]   = 1'($urandom_range(0, 1));
        unit_result[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run_test(input string name, input bit poke_start, input int abort_at);
    int         e;
    int         bad;
    int         b;
    int         j;
    bit         all_in;
    bit         exp_fail;
    logic       eb;
    logic [7:0] exp_bytes[N+2];
    logic [7:0] got_byte;
    logic       wave[REPORT_CYC];

    // Reference model: end of collection and the expected report text.
    e = 0;
    all_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (dc[i] > TMO) all_in = 1'b0;
      else if (dc[i] > e) e = dc[i];
    end
    if (!all_in) e = TMO;
    exp_fail = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (dc[i] > e) begin
        exp_bytes[i] = 8'h54;
        exp_fail = 1'b1;
      end else if (rd[i] || (fc[i] >= 1 && fc[i] <= dc[i])) begin
        exp_bytes[i] = 8'h46;
        exp_fail = 1'b1;
      end else begin
        exp_bytes[i] = 8'h50;
      end
    end
    exp_bytes[N]   = 8'h0D;
    exp_bytes[N+1] = 8'h0A;

    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, ":busy_arm"}, busy, 1);

    bad = 0;
    for (int k = 1; k <= e + 1; k++) begin
      if (k <= e) drive_run(k);
      else drive_noise();
      if (uart_tx !== 1'b1 || busy !== 1'b1 || complete !== 1'b0 || pass !== 1'b0 || fail !== 1'b0)
        bad++;
      tick();
    end
    check({name, ":run_phase"}, bad, 0);

    bad = 0;
    for (int c = 0; c < REPORT_CYC; c++) begin
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check({name, ":rst_tx"}, uart_tx, 1);
        check({name, ":rst_busy"}, busy, 0);
        check({name, ":rst_complete"}, complete, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        return;
      end
      b = c / FRAME_CYC;
      j = (c % FRAME_CYC) / DIV;
      if (j == 0) eb = 1'b0;
      else if (j == 9) eb = 1'b1;
      else eb = exp_bytes[b][j-1];
      wave[c] = uart_tx;
      if (uart_tx !== eb || busy !== 1'b1 || complete !== 1'b0 || pass !== 1'b0 || fail !== 1'b0)
        bad++;
      drive_noise();
      start = poke_start && (c == 50);
      tick();
    end
    start = 1'b0;
    check({name, ":tx_wave"}, bad, 0);

    for (int bi = 0; bi < N + 2; bi++) begin
      for (int bit_i = 0; bit_i < 8; bit_i++)
        got_byte[bit_i] = wave[bi * FRAME_CYC + (bit_i + 1) * DIV + DIV / 2];
      check($sformatf("%s:byte%0d", name, bi), got_byte, exp_bytes[bi]);
    end

    check({name, ":complete"}, complete, 1);
    check({name, ":busy_end"}, busy, 0);
    check({name, ":pass"}, pass, !exp_fail);
    check({name, ":fail"}, fail, exp_fail);
    repeat (3) tick();
    check({name, ":hold"}, {uart_tx, complete, busy, pass, fail}, {1'b1, 1'b1, 1'b0, !exp_fail, exp_fail});
  endtask

  initial begin
    int bad;
    repeat (3) tick();
    check("rst_tx", uart_tx, 1);
    check("rst_status", {busy, pass, fail, complete}, 4'b0000);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (uart_tx !== 1'b1 || {busy, pass, fail, complete} !== 4'b0000) bad++;
      drive_noise();
      tick();
    end
    check("idle_no_start", bad, 0);

    dc = '{5, 9, 12};     fc = '{0, 0, 0}; rd = '{0, 0, 0};
    run_test("all_pass", 1'b0, -1);
    dc = '{4, 7, 10};     fc = '{0, 3, 0}; rd = '{0, 0, 0};
    run_test("early_fail", 1'b0, -1);
    dc = '{5, 9, NEVER};  fc = '{0, 0, 0}; rd = '{0, 0, 0};
    run_test("timeout", 1'b0, -1);
    dc = '{3, 8, TMO};    fc = '{0, 0, 0}; rd = '{0, 0, 0};
    run_test("done_at_timeout", 1'b1, -1);
    dc = '{5, 6, 7};      fc = '{0, 0, 0}; rd = '{0, 0, 1};
    run_test("abort", 1'b0, FRAME_CYC + 5);
    run_test("rearm", 1'b0, -1);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        dc[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 72));
        fc[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : 0;
        rd[i] = ($urandom_range(0, 4) == 0);
      end
      run_test($sformatf("rand%0d", r), r[0], -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
